// File: rtl/mem_router_pkg.sv
// mem_router shared types and default address map.
// Windows are packed with slave 0 in the low slot.
package mem_router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERROR
  } router_state_t;

  localparam logic [31:0] SLAVE0_BASE_ADDR = 32'h0000_0000;
  localparam logic [31:0] SLAVE0_TOP_ADDR  = 32'h0010_0000;
  localparam logic [31:0] SLAVE1_BASE_ADDR = 32'h0010_0000;
  localparam logic [31:0] SLAVE1_TOP_ADDR  = 32'h0020_0000;
  localparam logic [31:0] SLAVE2_BASE_ADDR = 32'h0020_0000;
  localparam logic [31:0] SLAVE2_TOP_ADDR  = 32'h0030_0000;
  localparam logic [31:0] SLAVE3_BASE_ADDR = 32'h8000_0000;
  localparam logic [31:0] SLAVE3_TOP_ADDR  = 32'h8010_0000;

  localparam logic [127:0] DEF_BASE_ADDR = {
    SLAVE3_BASE_ADDR, SLAVE2_BASE_ADDR,
    SLAVE1_BASE_ADDR, SLAVE0_BASE_ADDR
  };
  localparam logic [127:0] DEF_TOP_ADDR = {
    SLAVE3_TOP_ADDR, SLAVE2_TOP_ADDR,
    SLAVE1_TOP_ADDR, SLAVE0_TOP_ADDR
  };

  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_router_if.sv
// Memory-side and slave-side buses of mem_router.
// slave: the router's view; master: the surrounding system.
interface mem_router_if #(
  parameter int SLAVES     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SW = DATA_WIDTH / 8;

  logic                         memory_valid;
  logic                         memory_instr;
  logic [ADDR_WIDTH-1:0]        memory_addr;
  logic [DATA_WIDTH-1:0]        memory_wdata;
  logic [SW-1:0]                memory_wstrb;
  logic [DATA_WIDTH-1:0]        memory_rdata;
  logic                         memory_ready;
  logic                         memory_error;

  logic [SLAVES-1:0]            slave_valid;
  logic                         slave_instr;
  logic [ADDR_WIDTH-1:0]        slave_addr;
  logic [DATA_WIDTH-1:0]        slave_wdata;
  logic [SW-1:0]                slave_wstrb;
  logic [SLAVES*DATA_WIDTH-1:0] slave_rdata;
  logic [SLAVES-1:0]            slave_ready;

  modport slave (
    input  memory_valid, memory_instr, memory_addr,
    input  memory_wdata, memory_wstrb,
    output memory_rdata, memory_ready, memory_error,
    output slave_valid, slave_instr, slave_addr,
    output slave_wdata, slave_wstrb,
    input  slave_rdata, slave_ready
  );

  modport master (
    output memory_valid, memory_instr, memory_addr,
    output memory_wdata, memory_wstrb,
    input  memory_rdata, memory_ready, memory_error,
    input  slave_valid, slave_instr, slave_addr,
    input  slave_wdata, slave_wstrb,
    output slave_rdata, slave_ready
  );
endinterface

// File: rtl/mem_router_decode.sv
// Priority window decoder: lowest matching slave index wins.
module mem_router_decode
  import mem_router_pkg::*;
#(
  parameter int SLAVES     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter logic [SLAVES*ADDR_WIDTH-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [SLAVES*ADDR_WIDTH-1:0] TOP_ADDR  = DEF_TOP_ADDR,
  parameter int IW = idx_width(SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [IW-1:0]         idx
);

  // Scan downwards so the lowest index is the last to assign.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if (addr >= BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] &&
          addr <  TOP_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/mem_router.sv
// Single-outstanding address router with unmapped/timeout
// error responses toward the memory master.
module mem_router
  import mem_router_pkg::*;
#(
  parameter int SLAVES     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [SLAVES*ADDR_WIDTH-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [SLAVES*ADDR_WIDTH-1:0] TOP_ADDR  = DEF_TOP_ADDR,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic         clock,
  input  logic         reset,
  mem_router_if.slave  bus,
  output logic         protocol_err
);

  localparam int IW = idx_width(SLAVES);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  router_state_t         state, state_nx;
  logic [IW-1:0]         sel, sel_nx;
  logic [TW-1:0]         timer;
  logic                  perr;

  logic                  hit;
  logic [IW-1:0]         idx;
  logic                  req;
  logic                  rdy, err;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  tmo;

  mem_router_decode #(
    .SLAVES     (SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .TOP_ADDR   (TOP_ADDR),
    .IW         (IW)
  ) u_decode (
    .addr (bus.memory_addr),
    .hit  (hit),
    .idx  (idx)
  );

  assign sel_ready = bus.slave_ready[sel];
  assign sel_rdata = bus.slave_rdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign tmo       = (timer == TW'(TIMEOUT));

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    req      = 1'b0;
    rdy      = 1'b0;
    err      = 1'b0;
    rdata    = '0;
    unique case (state)
      IDLE: begin
        if (bus.memory_valid) begin
          if (hit) begin
            state_nx = BUSY;
            sel_nx   = idx;
            req      = 1'b1;
          end else begin
            state_nx = ERROR;
          end
        end
      end
      // A slave answer in the timeout cycle still wins.
      BUSY: begin
        if (sel_ready) begin
          state_nx = IDLE;
          rdy      = 1'b1;
          rdata    = sel_rdata;
        end else if (tmo) begin
          state_nx = IDLE;
          rdy      = 1'b1;
          err      = 1'b1;
          rdata    = ERR_DATA;
        end
      end
      ERROR: begin
        state_nx = IDLE;
        rdy      = 1'b1;
        err      = 1'b1;
        rdata    = ERR_DATA;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      sel   <= '0;
      timer <= '0;
      perr  <= 1'b0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      if (state != BUSY)
        timer <= '0;
      else if (!tmo)
        timer <= timer + TW'(1);
      if (bus.memory_valid && state != IDLE)
        perr <= 1'b1;
    end
  end

  // Everything is held at zero while reset is low.
  assign bus.slave_valid  = (reset && req) ? (SLAVES'(1) << idx) : '0;
  assign bus.slave_instr  = reset & bus.memory_instr;
  assign bus.slave_addr   = reset ? bus.memory_addr -
    BASE_ADDR[int'(sel_nx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign bus.slave_wdata  = reset ? bus.memory_wdata : '0;
  assign bus.slave_wstrb  = reset ? bus.memory_wstrb : '0;
  assign bus.memory_ready = reset & rdy;
  assign bus.memory_error = reset & err;
  assign bus.memory_rdata = reset ? rdata : '0;
  assign protocol_err     = reset & perr;

endmodule

// File: tb/tb_mem_router.sv
// Bench for mem_router: vector table, corner sequences and
// randomized traffic against an address-map model.
module tb_mem_router;
  import mem_router_pkg::*;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic perr;

  always #5 clk = ~clk;

  mem_router_if bus ();

  mem_router #(.TIMEOUT(TO)) dut (
    .clock        (clk),
    .reset        (rst),
    .bus          (bus),
    .protocol_err (perr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] win_base [4] = '{32'h0, 32'h0010_0000,
                                32'h0020_0000, 32'h8000_0000};
  logic [31:0] win_top  [4] = '{32'h0010_0000, 32'h0020_0000,
                                32'h0030_0000, 32'h8010_0000};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int model_sel(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (a >= win_base[i] && a < win_top[i]) return i;
    return -1;
  endfunction

  task automatic model(input logic [31:0] a, input int dly,
                       input logic [31:0] srd, output int s,
                       output int lat, output logic err,
                       output logic [31:0] rd);
    s = model_sel(a);
    if (s < 0) begin
      lat = 1; err = 1'b1; rd = 32'hDEAD_BEEF;
    end else if (dly >= 1 && dly <= TO + 1) begin
      lat = dly; err = 1'b0; rd = srd;
    end else begin
      lat = TO + 1; err = 1'b1; rd = 32'hDEAD_BEEF;
    end
  endtask

  task automatic run_req(
    input  logic [31:0] a, input logic [3:0] st,
    input  logic [31:0] wd, input logic ins,
    input  int tgt, input int dly, input logic [31:0] srd,
    output logic [3:0] sv, output logic [31:0] sa,
    output logic [31:0] swd, output logic [3:0] sst,
    output logic sins, output int lat, output logic err,
    output logic [31:0] rd);
    lat = -1; err = 1'b0; rd = '0;
    @(negedge clk);
    bus.slave_rdata  = {$urandom, $urandom, $urandom, $urandom};
    bus.memory_valid = 1'b1;
    bus.memory_addr  = a;
    bus.memory_wstrb = st;
    bus.memory_wdata = wd;
    bus.memory_instr = ins;
    if (dly == 0 && tgt >= 0) begin
      bus.slave_ready[tgt] = 1'b1;
      bus.slave_rdata[tgt*32 +: 32] = srd;
    end
    #1;
    sv = bus.slave_valid; sa = bus.slave_addr;
    swd = bus.slave_wdata; sst = bus.slave_wstrb;
    sins = bus.slave_instr;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.memory_valid = 1'b0;
      bus.slave_ready  = '0;
      if (k == dly && tgt >= 0) begin
        bus.slave_ready[tgt] = 1'b1;
        bus.slave_rdata[tgt*32 +: 32] = srd;
      end
      #1;
      if (bus.memory_ready) begin
        lat = k; err = bus.memory_error; rd = bus.memory_rdata;
        break;
      end
    end
    @(negedge clk);
    bus.slave_ready = '0;
    #1;
    chk("ready_single_pulse", 32'(bus.memory_ready), 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        instr;
    int          tgt;
    int          dly;
    logic [31:0] srd;
    logic [3:0]  e_sv;
    logic        chk_sa;
    logic [31:0] e_sa;
    int          e_lat;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt [10];

  logic [3:0]  sv, sst;
  logic [31:0] sa, swd, rd, e_rd, ra;
  logic        sins, err, e_err;
  int          lat, e_lat, s, dly, w;

  initial begin
    vt[0] = '{32'h0010_0010, 4'h0, 32'h0, 1'b0, 1, 3, 32'h1234_5678,
              4'b0010, 1'b1, 32'h10, 3, 1'b0, 32'h1234_5678};
    vt[1] = '{32'h8000_0004, 4'hF, 32'hCAFE_F00D, 1'b0, 3, 1, 32'h1,
              4'b1000, 1'b1, 32'h4, 1, 1'b0, 32'h1};
    vt[2] = '{32'h4000_0000, 4'h0, 32'h0, 1'b0, -1, 0, 32'h0,
              4'b0000, 1'b0, 32'h0, 1, 1'b1, 32'hDEAD_BEEF};
    vt[3] = '{32'h0000_0040, 4'h0, 32'h0, 1'b0, 0, -1, 32'h0,
              4'b0001, 1'b1, 32'h40, 9, 1'b1, 32'hDEAD_BEEF};
    vt[4] = '{32'h002F_FFFC, 4'h3, 32'h1111_2222, 1'b0, 2, 9,
              32'hA5A5_A5A5, 4'b0100, 1'b1, 32'h000F_FFFC, 9, 1'b0,
              32'hA5A5_A5A5};
    vt[5] = '{32'h000F_FFFF, 4'h0, 32'h0, 1'b1, 0, 2, 32'h7777_0000,
              4'b0001, 1'b1, 32'h000F_FFFF, 2, 1'b0, 32'h7777_0000};
    vt[6] = '{32'h0030_0000, 4'h1, 32'h9, 1'b0, -1, 0, 32'h0,
              4'b0000, 1'b0, 32'h0, 1, 1'b1, 32'hDEAD_BEEF};
    vt[7] = '{32'h8000_0000, 4'hC, 32'h5555_AAAA, 1'b1, 3, 5,
              32'h0F0F_0F0F, 4'b1000, 1'b1, 32'h0, 5, 1'b0,
              32'h0F0F_0F0F};
    vt[8] = '{32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, -1, 0, 32'h0,
              4'b0000, 1'b0, 32'h0, 1, 1'b1, 32'hDEAD_BEEF};
    vt[9] = '{32'h001F_FFF0, 4'h0, 32'h0, 1'b0, 1, 0, 32'h3333_4444,
              4'b0010, 1'b1, 32'h000F_FFF0, 9, 1'b1, 32'hDEAD_BEEF};

    rst = 1'b0;
    bus.memory_valid = 1'b0;
    bus.memory_instr = 1'b0;
    bus.memory_addr  = '0;
    bus.memory_wdata = '0;
    bus.memory_wstrb = '0;
    bus.slave_rdata  = '0;
    bus.slave_ready  = '0;

    // Reset state with a request held on the bus
    @(negedge clk);
    bus.memory_valid = 1'b1;
    bus.memory_addr  = 32'h0010_0010;
    bus.memory_wdata = 32'hFFFF_FFFF;
    #1;
    chk("rst_slave_valid", 32'(bus.slave_valid), 32'd0);
    chk("rst_slave_addr", bus.slave_addr, 32'd0);
    chk("rst_slave_wdata", bus.slave_wdata, 32'd0);
    chk("rst_mem_ready", 32'(bus.memory_ready), 32'd0);
    chk("rst_perr", 32'(perr), 32'd0);
    @(negedge clk);
    bus.memory_valid = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_req(vt[i].addr, vt[i].wstrb, vt[i].wdata, vt[i].instr,
              vt[i].tgt, vt[i].dly, vt[i].srd,
              sv, sa, swd, sst, sins, lat, err, rd);
      chk($sformatf("vec%0d_slave_valid", i), 32'(sv), 32'(vt[i].e_sv));
      if (vt[i].chk_sa)
        chk($sformatf("vec%0d_slave_addr", i), sa, vt[i].e_sa);
      chk($sformatf("vec%0d_wdata", i), swd, vt[i].wdata);
      chk($sformatf("vec%0d_wstrb", i), 32'(sst), 32'(vt[i].wstrb));
      chk($sformatf("vec%0d_instr", i), 32'(sins), 32'(vt[i].instr));
      chk($sformatf("vec%0d_latency", i), lat, vt[i].e_lat);
      chk($sformatf("vec%0d_error", i), 32'(err), 32'(vt[i].e_err));
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].e_rd);
    end

    // Late answer after a timeout is discarded
    run_req(32'h80, 4'h0, 32'h0, 1'b0, 0, -1, 32'h0,
            sv, sa, swd, sst, sins, lat, err, rd);
    chk("tmo_latency", lat, TO + 1);
    chk("tmo_error", 32'(err), 32'd1);
    @(negedge clk);
    bus.slave_ready[0] = 1'b1;
    bus.slave_rdata[31:0] = 32'hBAAD_0000;
    #1;
    chk("late_ready_ignored", 32'(bus.memory_ready), 32'd0);
    @(negedge clk);
    bus.slave_ready = '0;
    #1;
    chk("late_ready_idle", 32'(bus.memory_ready), 32'd0);

    // Foreign ready and a request while busy
    @(negedge clk);
    bus.memory_valid = 1'b1;
    bus.memory_addr  = 32'h0010_0020;
    bus.memory_wstrb = 4'h0;
    #1;
    chk("seq5_slave_valid", 32'(bus.slave_valid), 32'b0010);
    @(negedge clk);
    bus.memory_valid = 1'b0;
    bus.slave_ready[2] = 1'b1;
    #1;
    chk("seq5_wrong_slave", 32'(bus.memory_ready), 32'd0);
    @(negedge clk);
    bus.slave_ready  = '0;
    bus.memory_valid = 1'b1;
    bus.memory_addr  = 32'h0;
    #1;
    chk("seq5_busy_drop", 32'(bus.slave_valid), 32'd0);
    chk("seq5_perr_pre", 32'(perr), 32'd0);
    @(negedge clk);
    bus.memory_valid = 1'b0;
    bus.slave_ready[1] = 1'b1;
    bus.slave_rdata[63:32] = 32'h600D_600D;
    #1;
    chk("seq5_ready", 32'(bus.memory_ready), 32'd1);
    chk("seq5_rdata", bus.memory_rdata, 32'h600D_600D);
    chk("seq5_error", 32'(bus.memory_error), 32'd0);
    chk("seq5_perr_set", 32'(perr), 32'd1);
    @(negedge clk);
    bus.slave_ready = '0;
    #1;
    chk("seq5_perr_sticky", 32'(perr), 32'd1);

    // Reset in the middle of a transaction
    @(negedge clk);
    bus.memory_valid = 1'b1;
    bus.memory_addr  = 32'h0010_0040;
    #1;
    chk("seq6_slave_valid", 32'(bus.slave_valid), 32'b0010);
    @(negedge clk);
    bus.memory_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.memory_valid = 1'b1;
    bus.memory_instr = 1'b1;
    bus.memory_wdata = 32'hFFFF_FFFF;
    bus.memory_wstrb = 4'hF;
    bus.slave_ready[1] = 1'b1;
    #1;
    chk("seq6_slave_valid_rst", 32'(bus.slave_valid), 32'd0);
    chk("seq6_slave_addr_rst", bus.slave_addr, 32'd0);
    chk("seq6_wdata_rst", bus.slave_wdata, 32'd0);
    chk("seq6_wstrb_rst", 32'(bus.slave_wstrb), 32'd0);
    chk("seq6_instr_rst", 32'(bus.slave_instr), 32'd0);
    chk("seq6_ready_rst", 32'(bus.memory_ready), 32'd0);
    chk("seq6_error_rst", 32'(bus.memory_error), 32'd0);
    chk("seq6_rdata_rst", bus.memory_rdata, 32'd0);
    chk("seq6_perr_rst", 32'(perr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.memory_valid = 1'b0;
    bus.memory_instr = 1'b0;
    #1;
    chk("seq6_stale_ready", 32'(bus.memory_ready), 32'd0);
    @(negedge clk);
    bus.slave_ready = '0;
    #1;
    chk("seq6_perr_cleared", 32'(perr), 32'd0);
    run_req(32'h0010_0044, 4'h0, 32'h0, 1'b0, 1, 2, 32'h1357_9BDF,
            sv, sa, swd, sst, sins, lat, err, rd);
    chk("seq6_after_valid", 32'(sv), 32'b0010);
    chk("seq6_after_latency", lat, 2);
    chk("seq6_after_rdata", rd, 32'h1357_9BDF);
    chk("seq6_after_error", 32'(err), 32'd0);

    // Randomized traffic against the address-map model
    for (int n = 0; n < 200; n++) begin
      w = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: ra = win_base[w] + 32'($urandom_range(0, 32'h000F_FFFF));
        1: ra = win_base[w];
        2: ra = win_top[w] - 32'd1;
        default: ra = (n % 2 == 0) ? win_top[w] : 32'($urandom);
      endcase
      dly = $urandom_range(0, 11);
      if (dly == 11) dly = -1;
      e_rd = 32'($urandom);
      model(ra, dly, e_rd, s, e_lat, e_err, e_rd);
      run_req(ra, 4'($urandom), 32'($urandom), 1'($urandom), s, dly,
              e_rd, sv, sa, swd, sst, sins, lat, err, rd);
      chk($sformatf("rnd%0d_valid", n), 32'(sv),
          (s < 0) ? 32'd0 : (32'd1 << s));
      if (s >= 0)
        chk($sformatf("rnd%0d_addr", n), sa, ra - win_base[s]);
      chk($sformatf("rnd%0d_latency", n), lat, e_lat);
      chk($sformatf("rnd%0d_error", n), 32'(err), 32'(e_err));
      chk($sformatf("rnd%0d_rdata", n), rd, e_rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
